pick_ctrl: RTL and testbench

PICK_CTRL -- requirements
Module: pick_ctrl

---
 rtl/pick_ctrl.sv | 156 +++++++++++++++
 tb/tb_pick_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pick_ctrl.sv
// pick_ctrl: frame sequencer for the pixel picker. Issues one GO per line,
// watches the PUSH strobe for a header timeout and for the line length,
// and reports a result code with a one-cycle DONE at the end of every frame.
module pick_ctrl #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned NUM_PIX   = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic        PUSH,
  output logic        GO,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  ERR_CODE,
  output logic [7:0]  LINE_IDX,
  output logic [15:0] FRAME_PIX
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_TMO   = 2'd1;
  localparam logic [1:0] E_LEN   = 2'd2;
  localparam logic [1:0] E_ABORT = 2'd3;

  localparam logic [7:0]  LAST_LINE = 8'(NUM_LINES - 1);
  localparam logic [7:0]  LINE_PIX  = 8'(NUM_PIX);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  lpix_q, lpix_d;
  logic [7:0]  line_q, line_d;
  logic [15:0] fpix_q, fpix_d;
  logic [1:0]  err_q, err_d;
  logic        go_q, busy_q, done_q;
  logic [15:0] fpix_inc;
  logic [7:0]  lpix_inc;

  // Saturating increments for the frame and line pixel counters
  always_comb begin
    fpix_inc = (fpix_q == 16'hFFFF) ? fpix_q : fpix_q + 16'd1;
    lpix_inc = (lpix_q == 8'hFF) ? lpix_q : lpix_q + 8'd1;
  end

  // Next-state and counter logic; ABORT is tested first in every active state
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    lpix_d  = lpix_q;
    line_d  = line_q;
    fpix_d  = fpix_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d = S_ISSUE;
          line_d  = '0;
          fpix_d  = '0;
          err_d   = E_OK;
          tmo_d   = '0;
          lpix_d  = '0;
        end
      end
      S_ISSUE: begin
        if (ABORT) begin
          state_d = S_FIN;
          err_d   = E_ABORT;
        end else begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end
      end
      S_WAIT: begin
        if (ABORT) begin
          state_d = S_FIN;
          err_d   = E_ABORT;
        end else if (PUSH) begin
          state_d = S_STREAM;
          lpix_d  = 8'd1;
          fpix_d  = fpix_inc;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FIN;
          err_d   = E_TMO;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_STREAM: begin
        if (ABORT) begin
          state_d = S_FIN;
          err_d   = E_ABORT;
        end else if (PUSH) begin
          fpix_d = fpix_inc;
          lpix_d = lpix_inc;
          if (lpix_q > LINE_PIX) begin
            state_d = S_FIN;
            err_d   = E_LEN;
          end
        end else if (lpix_q != LINE_PIX) begin
          state_d = S_FIN;
          err_d   = E_LEN;
        end else if (line_q == LAST_LINE) begin
          state_d = S_FIN;
          err_d   = E_OK;
        end else begin
          state_d = S_ISSUE;
          line_d  = line_q + 8'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; GO/BUSY/DONE are decoded from the next state
  // so that they are flops aligned with the state they describe
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      lpix_q  <= '0;
      line_q  <= '0;
      fpix_q  <= '0;
      err_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      lpix_q  <= lpix_d;
      line_q  <= line_d;
      fpix_q  <= fpix_d;
      err_q   <= err_d;
      go_q    <= (state_d == S_ISSUE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIN);
    end
  end

  assign GO        = go_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR_CODE  = err_q;
  assign LINE_IDX  = line_q;
  assign FRAME_PIX = fpix_q;

endmodule

// File: tb/tb_pick_ctrl.sv
// tb_pick_ctrl: scenario tasks with a scoreboard of expected frame results.
module tb_pick_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, PUSH;
  logic        GO, BUSY, DONE;
  logic [1:0]  ERR_CODE;
  logic [7:0]  LINE_IDX;
  logic [15:0] FRAME_PIX;

  logic        START2, ABORT2, PUSH2;
  logic        GO2, BUSY2, DONE2;
  logic [1:0]  ERR2;
  logic [7:0]  LINE2;
  logic [15:0] FPIX2;

  always #5 CLK = ~CLK;

  pick_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .PUSH(PUSH),
    .GO(GO), .BUSY(BUSY), .DONE(DONE), .ERR_CODE(ERR_CODE),
    .LINE_IDX(LINE_IDX), .FRAME_PIX(FRAME_PIX)
  );

  pick_ctrl #(.TIMEOUT(20)) dut_tmo (
    .CLK(CLK), .RST(RST), .START(START2), .ABORT(ABORT2), .PUSH(PUSH2),
    .GO(GO2), .BUSY(BUSY2), .DONE(DONE2), .ERR_CODE(ERR2),
    .LINE_IDX(LINE2), .FRAME_PIX(FPIX2)
  );

  typedef struct packed {
    logic [1:0]  err;
    logic [7:0]  line;
    logic [15:0] fpix;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // responder configuration and observations
  int   lens[$];
  int   evt_kind = 0;   // 0 none, 1 abort, 2 reset
  int   evt_line = 0;
  int   evt_push = 0;
  bit   start_noise = 0;
  int   cyc, go_cnt, done_cnt, go_dbl, done_cyc, last_push_cyc;
  logic [1:0]  d_err;
  logic [7:0]  d_line;
  logic [15:0] d_fpix;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Starts a frame and answers each GO with lens[line] PUSH cycles three
  // cycles later; stops on DONE, on a planted reset, or after max_cyc.
  task automatic run_frame(input int max_cyc);
    int ps, pe, cur_line, line_push;
    bit p, prev_go;
    ps = -1; pe = -2; cur_line = -1; line_push = 0; prev_go = 0;
    go_cnt = 0; done_cnt = 0; go_dbl = 0; done_cyc = -1; last_push_cyc = -1;
    cyc = 0;
    tick();
    START = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      START = 1'b0;
      if (GO) begin
        if (prev_go) go_dbl++;
        go_cnt++;
        cur_line  = go_cnt - 1;
        line_push = 0;
        ps = cyc + 3;
        pe = cyc + 2 + ((cur_line < lens.size()) ? lens[cur_line] : 0);
      end
      prev_go = GO;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        d_err = ERR_CODE; d_line = LINE_IDX; d_fpix = FRAME_PIX;
        PUSH = 1'b0; ABORT = 1'b0;
        break;
      end
      p = (cyc >= ps) && (cyc <= pe);
      if (p) begin
        line_push++;
        last_push_cyc = cyc;
      end
      PUSH  = p;
      ABORT = (evt_kind == 1) && (cur_line == evt_line) && p && (line_push == evt_push);
      if (start_noise && p) START = 1'b1;
      if ((evt_kind == 2) && (cur_line == evt_line) && p && (line_push == evt_push)) begin
        RST  = 1'b1;
        PUSH = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 0; ABORT = 0; PUSH = 0; START2 = 0; ABORT2 = 0; PUSH2 = 0;
    repeat (3) tick();
    n_cmp++;
    if ({GO, BUSY, DONE, ERR_CODE, LINE_IDX, FRAME_PIX} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", {GO, BUSY, DONE, ERR_CODE, LINE_IDX, FRAME_PIX});
    end
    n_cmp++;
    if ({GO2, BUSY2, DONE2, ERR2, LINE2, FPIX2} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs_tmo: got %h expected 0", {GO2, BUSY2, DONE2, ERR2, LINE2, FPIX2});
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignore();
    START = 1'b1; ABORT = 1'b1; PUSH = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({GO, BUSY} !== 2'b00) begin
      n_bad++;
      $display("FAIL start_with_abort: got GO,BUSY=%b expected 00", {GO, BUSY});
    end
    n_cmp++;
    if (FRAME_PIX !== 16'd0) begin
      n_bad++;
      $display("FAIL idle_push: got FRAME_PIX=%0d expected 0", FRAME_PIX);
    end
    START = 1'b0; ABORT = 1'b0; PUSH = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    exp_t e;
    lens = '{16, 16, 16, 16, 16, 16, 16, 16};
    exp_q.push_back(exp_t'{2'd0, 8'd7, 16'd128});
    run_frame(400);
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL nom_done: got %0d DONE expected 1", done_cnt); end
    n_cmp++;
    if (go_cnt !== 8) begin n_bad++; $display("FAIL nom_go_count: got %0d expected 8", go_cnt); end
    n_cmp++;
    if (go_dbl !== 0) begin n_bad++; $display("FAIL nom_go_double: got %0d expected 0", go_dbl); end
    e = exp_q.pop_front();
    n_cmp++;
    if (d_err !== e.err) begin n_bad++; $display("FAIL nom_err: got %0d expected %0d", d_err, e.err); end
    n_cmp++;
    if (d_line !== e.line) begin n_bad++; $display("FAIL nom_line: got %0d expected %0d", d_line, e.line); end
    n_cmp++;
    if (d_fpix !== e.fpix) begin n_bad++; $display("FAIL nom_fpix: got %0d expected %0d", d_fpix, e.fpix); end
    tick();
    n_cmp++;
    if ({DONE, BUSY} !== 2'b00) begin n_bad++; $display("FAIL nom_done_width: got DONE,BUSY=%b expected 00", {DONE, BUSY}); end
    n_cmp++;
    if ({ERR_CODE, LINE_IDX, FRAME_PIX} !== {e.err, e.line, e.fpix}) begin
      n_bad++;
      $display("FAIL nom_hold: got %h expected %h", {ERR_CODE, LINE_IDX, FRAME_PIX}, {e.err, e.line, e.fpix});
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int g, dcyc;
    bit seen;
    exp_q.push_back(exp_t'{2'd1, 8'd0, 16'd0});
    cyc = 0; g = -1; dcyc = -1; seen = 0;
    tick();
    START2 = 1'b1;
    tick();
    START2 = 1'b0;
    if (GO2) g = cyc;
    n_cmp++;
    if (g < 0) begin n_bad++; $display("FAIL tmo_go: got GO2=%b expected 1", GO2); end
    for (int k = 0; k < 100; k++) begin
      tick();
      if (DONE2) begin dcyc = cyc; seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL tmo_done: got no DONE expected DONE"); end
    n_cmp++;
    if (dcyc - g !== 21) begin n_bad++; $display("FAIL tmo_latency: got %0d expected 21", dcyc - g); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({ERR2, LINE2, FPIX2} !== {e.err, e.line, e.fpix}) begin
      n_bad++;
      $display("FAIL tmo_result: got %h expected %h", {ERR2, LINE2, FPIX2}, {e.err, e.line, e.fpix});
    end
    tick();
    n_cmp++;
    if (BUSY2 !== 1'b0) begin n_bad++; $display("FAIL tmo_busy: got %b expected 0", BUSY2); end
  endtask

  task automatic test_short_line();
    exp_t e;
    lens = '{16, 16, 15, 16, 16, 16, 16, 16};
    exp_q.push_back(exp_t'{2'd2, 8'd2, 16'd47});
    run_frame(400);
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL short_done: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (done_cyc - last_push_cyc !== 2) begin
      n_bad++;
      $display("FAIL short_latency: got %0d expected 2", done_cyc - last_push_cyc);
    end
    n_cmp++;
    if (go_cnt !== 3) begin n_bad++; $display("FAIL short_go_count: got %0d expected 3", go_cnt); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({d_err, d_line, d_fpix} !== {e.err, e.line, e.fpix}) begin
      n_bad++;
      $display("FAIL short_result: got %h expected %h", {d_err, d_line, d_fpix}, {e.err, e.line, e.fpix});
    end
    tick();
  endtask

  task automatic test_long_line();
    exp_t e;
    int extra_go;
    lens = '{18, 16, 16, 16, 16, 16, 16, 16};
    exp_q.push_back(exp_t'{2'd2, 8'd0, 16'd0});
    run_frame(200);
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL long_done: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (done_cyc - last_push_cyc !== 1) begin
      n_bad++;
      $display("FAIL long_latency: got %0d expected 1", done_cyc - last_push_cyc);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({d_err, d_line} !== {e.err, e.line}) begin
      n_bad++;
      $display("FAIL long_result: got %h expected %h", {d_err, d_line}, {e.err, e.line});
    end
    extra_go = 0;
    repeat (10) begin
      tick();
      if (GO) extra_go++;
    end
    n_cmp++;
    if (go_cnt + extra_go !== 1) begin
      n_bad++;
      $display("FAIL long_go_count: got %0d expected 1", go_cnt + extra_go);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int abort_cyc, stray_go;
    lens = '{16, 16, 16, 16, 16, 16, 16, 16};
    evt_kind = 1; evt_line = 1; evt_push = 6; start_noise = 1;
    exp_q.push_back(exp_t'{2'd3, 8'd1, 16'd21});
    run_frame(200);
    abort_cyc = last_push_cyc;
    evt_kind = 0; start_noise = 0; START = 1'b0;
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL abort_done: got %0d expected 1", done_cnt); end
    n_cmp++;
    if (done_cyc - abort_cyc !== 1) begin
      n_bad++;
      $display("FAIL abort_latency: got %0d expected 1", done_cyc - abort_cyc);
    end
    n_cmp++;
    if (go_cnt !== 2) begin n_bad++; $display("FAIL abort_go_count: got %0d expected 2", go_cnt); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({d_err, d_line, d_fpix} !== {e.err, e.line, e.fpix}) begin
      n_bad++;
      $display("FAIL abort_result: got %h expected %h", {d_err, d_line, d_fpix}, {e.err, e.line, e.fpix});
    end
    tick();
    n_cmp++;
    if ({BUSY, ERR_CODE} !== 3'b011) begin
      n_bad++;
      $display("FAIL abort_after: got BUSY,ERR=%b expected 011", {BUSY, ERR_CODE});
    end
    stray_go = 0;
    repeat (5) begin
      tick();
      if (GO || BUSY) stray_go++;
    end
    n_cmp++;
    if (stray_go !== 0) begin n_bad++; $display("FAIL abort_start_ignored: got %0d active cycles expected 0", stray_go); end
  endtask

  task automatic test_reset_mid_stream();
    exp_t e;
    int late_done;
    lens = '{16, 16, 16, 16, 16, 16, 16, 16};
    evt_kind = 2; evt_line = 4; evt_push = 8;
    run_frame(400);
    evt_kind = 0;
    n_cmp++;
    if (RST !== 1'b1) begin n_bad++; $display("FAIL rst_reached_line4: got RST=%b expected 1", RST); end
    tick();
    n_cmp++;
    if ({GO, BUSY, DONE, ERR_CODE, LINE_IDX, FRAME_PIX} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {GO, BUSY, DONE, ERR_CODE, LINE_IDX, FRAME_PIX});
    end
    RST = 1'b0;
    late_done = 0;
    repeat (5) begin
      tick();
      if (DONE) late_done++;
    end
    n_cmp++;
    if (late_done !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d expected 0", late_done); end
    exp_q.push_back(exp_t'{2'd0, 8'd7, 16'd128});
    run_frame(400);
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL rst_next_done: got %0d expected 1", done_cnt); end
    e = exp_q.pop_front();
    n_cmp++;
    if ({d_err, d_line, d_fpix} !== {e.err, e.line, e.fpix}) begin
      n_bad++;
      $display("FAIL rst_next_result: got %h expected %h", {d_err, d_line, d_fpix}, {e.err, e.line, e.fpix});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_nominal();
    test_timeout();
    test_short_line();
    test_long_line();
    test_abort();
    test_reset_mid_stream();
    n_cmp++;
    if (exp_q.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
